if_id_skid: RTL and testbench
=============================

// Module: if_id_skid
// PURPOSE
//  Parametrised IF/ID pipeline register with valid/ready handshake and 2-entry skid buffer.
//  Sits between fetch and decode and replaces the single hold/flush register stage.
//  Adds separate stall (backpressure) and flush (kill), registered in_ready and full throughput.
//  Emits a NOP instruction whenever the output is not valid.
// PARAMETERS
//  INST_W    32            instruction width
//  ADDR_W    32            instruction address width
//  NOP_INST  32'h00000013  value driven on inst_dly when empty/flushed (addi x0,x0,0)
// PORTS
//  sys_clk        in   1       clock, all state on rising edge
//  sys_rst_n      in   1       reset, asynchronous, active-low
//  flush_i        in   1       synchronous kill of all held and incoming beats
//  in_valid       in   1       fetch presents inst/inst_addr
//  in_ready       out  1       stage can accept a beat; registered
//  inst           in   INST_W  fetched instruction
//  inst_addr      in   ADDR_W  fetched instruction address
//  out_valid      out  1       inst_dly/inst_addr_dly hold a live beat
//  out_ready      in   1       decode consumes the beat
//  inst_dly       out  INST_W  instruction to decode
//  inst_addr_dly  out  ADDR_W  address to decode
//  bubble_cnt     out  32      only with IF_ID_PERF_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): out_valid=0, in_ready=1, inst_dly=NOP_INST, inst_addr_dly=0, skid empty.
//  - Accept = in_valid & in_ready; drain = out_valid & out_ready; both on same edge allowed.
//  - Storage: main reg (drives outputs) + skid reg. States: EMPTY, ONE (main only), FULL (both).
//  - EMPTY: accept -> ONE, beat in main next cycle (1-cycle latency).
//  - ONE: accept&drain -> ONE (new beat in main); accept only -> FULL (beat to skid);
//    drain only -> EMPTY; neither -> hold.
//  - FULL: in_ready=0; drain -> ONE (skid moves to main, skid cleared); else hold.
//  - in_ready = ~skid_valid (registered, no comb path from out_ready).
//  - Order strictly FIFO; no beat duplicated or dropped except by flush.
//  - Throughput 1 beat/cycle while out_ready=1.
//  - Whenever out_valid=0: inst_dly=NOP_INST, inst_addr_dly=0 (decode may ignore valid).
//  - Held outputs stable while out_valid=1 & out_ready=0.
//  - flush_i=1: highest priority; next cycle state EMPTY, in_ready=1, outputs NOP/0;
//    beat offered in the flush cycle is discarded; drain in flush cycle still counts as consumed.
//  - flush_i and in_valid held high: beats accepted again from first cycle flush_i=0.
//  - Reset asserted mid-transfer: all state cleared immediately, no partial beat survives.
// CONFIGURATION
//  - IF_ID_PERF_CNT_EN defined: bubble_cnt port present; 32-bit counter, reset 0,
//    +1 each cycle out_ready=1 & out_valid=0; wraps at 2^32-1 -> 0; not cleared by flush.
//  - Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - Reset: hold sys_rst_n=0 -> out_valid=0, in_ready=1, inst_dly=0x00000013, inst_addr_dly=0.
//  - Stream: 8 beats addr 0x0..0x1C, out_ready=1 -> outputs 1 cycle later, one per cycle, in order.
//  - Stall: out_ready=0 with beats A,B,C offered -> A held on outputs, B in skid, in_ready=0, C not taken;
//    release out_ready -> A,B,C delivered in order, none lost.
//  - Flush in FULL state with new beat offered -> next cycle out_valid=0, inst_dly=NOP, in_ready=1;
//    next accepted beat appears as sole output.
//  - Simultaneous accept+drain in ONE for 4 cycles -> state stays ONE, in_ready never drops.
//  - IF_ID_PERF_CNT_EN: out_ready=1, in_valid=0 for 5 cycles after reset -> bubble_cnt=5; preload wrap check 0xFFFFFFFF -> 0.

Source files
------------

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// The main register drives decode; the skid register catches the one beat that
// is in flight when decode stalls, so in_ready can come straight from a flop.
// Optional feature macro: IF_ID_PERF_CNT_EN adds a bubble_cnt output, a 32-bit
// count of the cycles where decode was ready but no beat was valid.
module if_id_skid #(
    parameter int                 INST_W   = 32,
    parameter int                 ADDR_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = 'h00000013
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst_dly,
    output logic [ADDR_W-1:0] inst_addr_dly
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state_q, state_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d;
    logic [ADDR_W-1:0] main_addr_q, main_addr_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
    logic              accept, drain;

    // Both flags derive only from the state flop, so there is no comb path from out_ready.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // Decode sees a NOP at address 0 whenever nothing live is held.
    assign inst_dly      = out_valid ? main_inst_q : NOP_INST;
    assign inst_addr_dly = out_valid ? main_addr_q : '0;

    // State and storage registers; reset clears every held beat immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= EMPTY;
            main_inst_q <= NOP_INST;
            main_addr_q <= '0;
            skid_inst_q <= NOP_INST;
            skid_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            main_inst_q <= main_inst_d;
            main_addr_q <= main_addr_d;
            skid_inst_q <= skid_inst_d;
            skid_addr_q <= skid_addr_d;
        end
    end

    // Next-state and data steering; flush wins over every other event.
    always_comb begin
        state_d     = state_q;
        main_inst_d = main_inst_q;
        main_addr_d = main_addr_q;
        skid_inst_d = skid_inst_q;
        skid_addr_d = skid_addr_q;
        if (flush_i) begin
            state_d     = EMPTY;
            main_inst_d = NOP_INST;
            main_addr_d = '0;
            skid_inst_d = NOP_INST;
            skid_addr_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_inst_d = inst;
                        main_addr_d = inst_addr;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_inst_d = inst;
                        main_addr_d = inst_addr;
                    end else if (accept) begin
                        state_d     = FULL;
                        skid_inst_d = inst;
                        skid_addr_d = inst_addr;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d     = ONE;
                        main_inst_d = skid_inst_q;
                        main_addr_d = skid_addr_q;
                        skid_inst_d = NOP_INST;
                        skid_addr_d = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    // Bubble counter: decode ready with nothing to give; wraps naturally, survives flush.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            bubble_cnt <= '0;
        else if (out_ready && !out_valid)
            bubble_cnt <= bubble_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Randomised and directed bench for if_id_skid. The reference model is a plain
// FIFO of capacity 2: beats are pushed when fetch hands one over, popped when
// decode takes one, and emptied by flush or reset. A negedge monitor compares
// the DUT outputs against the head of that queue every cycle.
module tb_if_id_skid;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
    } beat_t;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              flush_i = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [INST_W-1:0] inst = '0;
    logic [ADDR_W-1:0] inst_addr = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [INST_W-1:0] inst_dly;
    logic [ADDR_W-1:0] inst_addr_dly;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0]       bubble_cnt;
`endif

    if_id_skid #(.INST_W(INST_W), .ADDR_W(ADDR_W), .NOP_INST(NOP)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .flush_i       (flush_i),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .inst          (inst),
        .inst_addr     (inst_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .inst_dly      (inst_dly),
        .inst_addr_dly (inst_addr_dly)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .bubble_cnt    (bubble_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    beat_t exp_q[$];
    beat_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%08h exp=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor and model: compare against the queue, then advance it by the
    // handshake that will happen on the coming rising edge.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            bit exp_v, acc, drn;
            exp_v = (exp_q.size() > 0);
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
            if (exp_v) begin
                chk("inst_dly", inst_dly, exp_q[0].inst);
                chk("inst_addr_dly", inst_addr_dly, exp_q[0].addr);
            end else begin
                chk("nop_inst", inst_dly, NOP);
                chk("nop_addr", inst_addr_dly, 32'd0);
            end
            acc = in_valid && (exp_q.size() < 2);
            drn = exp_v && out_ready;
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (drn) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(cur);
            end
            // fetch moves on once its beat is taken (or killed by flush)
            if (acc || flush_i) begin
                cur.addr = cur.addr + 32'd4;
                cur.inst = $urandom;
            end
        end
    end

    task automatic step(input bit v, input bit r, input bit f);
        @(posedge sys_clk);
        #1;
        in_valid  = v;
        out_ready = r;
        flush_i   = f;
        inst      = cur.inst;
        inst_addr = cur.addr;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_inst_dly"}, inst_dly, NOP);
        chk({tag, "_inst_addr_dly"}, inst_addr_dly, 32'd0);
    endtask

    initial begin
        cur.addr = 32'h0;
        cur.inst = $urandom;

        // reset held low
        #12;
        chk_reset_state("rst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

`ifdef IF_ID_PERF_CNT_EN
        // five idle cycles with decode ready -> five bubbles
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("bubble_cnt", bubble_cnt, 32'd5);
`endif
        mon_en = 1'b1;

        // stream of 8 beats at full rate (also exercises accept+drain in ONE)
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // stall: A held, B in skid, C refused; then release
        repeat (4) step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0);

        // fill, then flush with a beat offered, then one fresh beat
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // flush and in_valid both held high, then flush drops
        repeat (3) step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);

        // fill then reset mid-transfer
        repeat (3) step(1'b1, 1'b0, 1'b0);
        @(posedge sys_clk);
        #2;
        mon_en    = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        exp_q.delete();
        in_valid = 1'b0;
        flush_i  = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;

        // more random traffic after reset recovery
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2);
        repeat (4) step(1'b0, 1'b1, 1'b0);

        @(negedge sys_clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
